// File: rtl/regfile_write_sched.sv
// Register-file write scheduler.
// Arbitrates two write requesters onto a single register-file write port.
// Ties are broken round-robin. The winning write is registered and presented
// to the register-file decoder one cycle later.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   reqN_valid/addr/data     requester N write request (N = 0, 1)
//   reqN_ready               combinational accept; a transfer is valid & ready
//   hold                     blocks new grants while high
//   rf_ld/rf_addr/rf_data    registered write strobe, select and data
//   grant_id                 requester that produced the current rf_ld
//   reg_written              sticky per-register "written since reset" flags
//   wr_count                 8-bit wrapping count of committed writes
module regfile_write_sched #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [ADDR_W-1:0]        req0_addr,
  input  logic [DATA_W-1:0]        req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_W-1:0]        req1_addr,
  input  logic [DATA_W-1:0]        req1_data,
  output logic                     req1_ready,
  input  logic                     hold,
  output logic                     rf_ld,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  output logic                     grant_id,
  output logic [(2**ADDR_W)-1:0]   reg_written,
  output logic [7:0]               wr_count
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  // Round-robin pointer: 0 means requester 0 wins a tie, 1 means requester 1.
  logic              ptr;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grant decision; ready is forced low during reset and while hold is high.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && !hold) begin
      if (req0_valid && (!req1_valid || !ptr)) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  // Winning request payload; only meaningful when xfer is high.
  always_comb begin
    xfer     = req0_ready | req1_ready;
    sel_addr = req1_ready ? req1_addr : req0_addr;
    sel_data = req1_ready ? req1_data : req0_data;
  end

  // Registered write port, pointer, written flags and commit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= 1'b0;
      rf_ld       <= 1'b0;
      rf_addr     <= '0;
      rf_data     <= '0;
      grant_id    <= 1'b0;
      reg_written <= '0;
      wr_count    <= '0;
    end else begin
      rf_ld <= xfer;
      if (xfer) begin
        rf_addr     <= sel_addr;
        rf_data     <= sel_data;
        grant_id    <= req1_ready;
        // Pointer moves to whichever requester was not granted.
        ptr         <= ~req1_ready;
        wr_count    <= wr_count + 8'd1;
        reg_written <= reg_written | (NREG'(1) << sel_addr);
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Self-checking bench for regfile_write_sched: a directed vector table,
// hand-written corner sequences and constrained-random traffic checked
// against a behavioural model of the arbitration rules.
module tb_regfile_write_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, hold;
  logic [3:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_ld, grant_id;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic [15:0] reg_written;
  logic [7:0]  wr_count;

  regfile_write_sched #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .hold(hold),
    .rf_ld(rf_ld), .rf_addr(rf_addr), .rf_data(rf_data), .grant_id(grant_id),
    .reg_written(reg_written), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: who wins a tie, last write presented, flags and count.
  int          m_pref;
  logic        m_ld;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  logic        m_gid;
  logic [15:0] m_wr;
  int          m_count;
  logic [31:0] tb_rf [16];
  logic        s_r0, s_r1;

  task automatic model_reset();
    m_pref = 0; m_ld = 0; m_addr = 0; m_data = 0; m_gid = 0; m_wr = 0; m_count = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rf_ld"}, 64'(rf_ld), 64'(m_ld));
    check({tag, ".rf_addr"}, 64'(rf_addr), 64'(m_addr));
    check({tag, ".rf_data"}, 64'(rf_data), 64'(m_data));
    check({tag, ".grant_id"}, 64'(grant_id), 64'(m_gid));
    check({tag, ".reg_written"}, 64'(reg_written), 64'(m_wr));
    check({tag, ".wr_count"}, 64'(wr_count), 64'(m_count));
  endtask

  // One clock cycle: called just after a rising edge; drives, checks ready,
  // advances the model across the edge and checks the registered outputs.
  task automatic step(input logic v0, input logic [3:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [3:0] a1, input logic [31:0] d1,
                      input logic h, input string tag);
    logic e0, e1;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    hold = h;
    @(negedge clk);
    e0 = 0; e1 = 0;
    if (!h) begin
      if (v0 && v1) begin
        if (m_pref == 0) e0 = 1; else e1 = 1;
      end else begin
        e0 = v0; e1 = v1;
      end
    end
    s_r0 = req0_ready; s_r1 = req1_ready;
    check({tag, ".req0_ready"}, 64'(req0_ready), 64'(e0));
    check({tag, ".req1_ready"}, 64'(req1_ready), 64'(e1));
    @(posedge clk);
    #1;
    m_ld = e0 | e1;
    if (e0 | e1) begin
      m_addr  = e1 ? a1 : a0;
      m_data  = e1 ? d1 : d0;
      m_gid   = e1;
      m_wr[m_addr] = 1'b1;
      m_count = (m_count + 1) % 256;
      m_pref  = e1 ? 0 : 1;
    end
    check_outputs(tag);
    if (rf_ld) tb_rf[rf_addr] = rf_data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; hold = 1'b0;
    req0_addr = 4'd1; req1_addr = 4'd2; req0_data = 32'h1; req1_data = 32'h2;
    #1;
    model_reset();
    check("rst.req0_ready", 64'(req0_ready), 64'd0);
    check("rst.req1_ready", 64'(req1_ready), 64'd0);
    check_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  typedef struct {
    logic v0; logic [3:0] a0; logic [31:0] d0;
    logic v1; logic [3:0] a1; logic [31:0] d1;
    logic h;
    logic r0, r1, ld; logic [3:0] addr; logic [31:0] data; logic gid;
    logic [15:0] wr; logic [7:0] cnt;
  } vec_t;

  vec_t vecs [9];
  int   exp_a [4] = '{1, 9, 2, 10};

  initial begin
    vecs[0] = '{1'b1, 4'd3, 32'hA5A5A5A5, 1'b0, 4'd0, 32'h0, 1'b0,
                1'b1, 1'b0, 1'b1, 4'd3, 32'hA5A5A5A5, 1'b0, 16'h0008, 8'd1};
    vecs[1] = '{1'b1, 4'd1, 32'h101, 1'b1, 4'd9, 32'h909, 1'b0,
                1'b0, 1'b1, 1'b1, 4'd9, 32'h909, 1'b1, 16'h0208, 8'd2};
    vecs[2] = '{1'b1, 4'd1, 32'h101, 1'b1, 4'd9, 32'h909, 1'b0,
                1'b1, 1'b0, 1'b1, 4'd1, 32'h101, 1'b0, 16'h020A, 8'd3};
    vecs[3] = '{1'b1, 4'd4, 32'h404, 1'b1, 4'd9, 32'h909, 1'b1,
                1'b0, 1'b0, 1'b0, 4'd1, 32'h101, 1'b0, 16'h020A, 8'd3};
    vecs[4] = '{1'b0, 4'd4, 32'h404, 1'b0, 4'd9, 32'h909, 1'b0,
                1'b0, 1'b0, 1'b0, 4'd1, 32'h101, 1'b0, 16'h020A, 8'd3};
    vecs[5] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'hF, 1'b0,
                1'b0, 1'b1, 1'b1, 4'd15, 32'hF, 1'b1, 16'h820A, 8'd4};
    vecs[6] = '{1'b1, 4'd2, 32'h2, 1'b0, 4'd0, 32'h0, 1'b0,
                1'b1, 1'b0, 1'b1, 4'd2, 32'h2, 1'b0, 16'h820E, 8'd5};
    vecs[7] = '{1'b1, 4'd7, 32'h7, 1'b0, 4'd0, 32'h0, 1'b0,
                1'b1, 1'b0, 1'b1, 4'd7, 32'h7, 1'b0, 16'h828E, 8'd6};
    vecs[8] = '{1'b1, 4'd4, 32'h4, 1'b1, 4'd12, 32'hC, 1'b0,
                1'b0, 1'b1, 1'b1, 4'd12, 32'hC, 1'b1, 16'h928E, 8'd7};
  end

  // Safety net against a stuck run.
  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic       c_v0, c_v1, c_h;
    logic [3:0] c_a0, c_a1;
    logic [31:0] c_d0, c_d1;
    int n0, n1;
    for (int i = 0; i < 16; i++) tb_rf[i] = 32'h0;
    s_r0 = 0; s_r1 = 0;
    hold = 0; reset = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed table from reset.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1,
           vecs[i].h, "vec");
      check("vec.t_r0", 64'(s_r0), 64'(vecs[i].r0));
      check("vec.t_r1", 64'(s_r1), 64'(vecs[i].r1));
      check("vec.t_ld", 64'(rf_ld), 64'(vecs[i].ld));
      check("vec.t_addr", 64'(rf_addr), 64'(vecs[i].addr));
      check("vec.t_data", 64'(rf_data), 64'(vecs[i].data));
      check("vec.t_gid", 64'(grant_id), 64'(vecs[i].gid));
      check("vec.t_wr", 64'(reg_written), 64'(vecs[i].wr));
      check("vec.t_cnt", 64'(wr_count), 64'(vecs[i].cnt));
    end

    // Alternating grants with both requesters continuously valid.
    do_reset();
    n0 = 0; n1 = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'(1 + n0), 32'(100 + n0), 1'b1, 4'(9 + n1), 32'(200 + n1), 1'b0, "alt");
      check("alt.gid", 64'(grant_id), 64'(k % 2));
      check("alt.addr", 64'(rf_addr), 64'(exp_a[k]));
      if (s_r0) n0++;
      if (s_r1) n1++;
    end
    check("alt.count", 64'(wr_count), 64'd4);

    // Same-address collision: grant order decides final content.
    do_reset();
    step(1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0, "same");
    check("same.first", 64'(rf_data), 64'h11);
    step(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 32'h22, 1'b0, "same");
    check("same.second", 64'(rf_data), 64'h22);
    check("same.final", 64'(tb_rf[5]), 64'h22);

    // Hold for three cycles after a registered write, then resume at pointer.
    do_reset();
    step(1'b1, 4'd6, 32'h66, 1'b1, 4'd8, 32'h88, 1'b0, "hold");
    check("hold.pre_ld", 64'(rf_ld), 64'd1);
    for (int k = 0; k < 3; k++)
      step(1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88, 1'b1, "hold");
    check("hold.ld_off", 64'(rf_ld), 64'd0);
    step(1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88, 1'b0, "hold");
    check("hold.resume_r1", 64'(s_r1), 64'd1);

    // 256 writes wrap the counter; every address gets used.
    do_reset();
    for (int i = 0; i < 256; i++)
      step(1'b1, 4'(i), 32'(i * 3), 1'b0, 4'd0, 32'h0, 1'b0, "wrap");
    check("wrap.count", 64'(wr_count), 64'd0);
    check("wrap.written", 64'(reg_written), 64'hFFFF);

    // Asynchronous reset right after a transfer discards the pending write.
    do_reset();
    step(1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 32'h0, 1'b0, "areset");
    req0_valid = 1'b1; req0_addr = 4'd6; req0_data = 32'h66;
    #2;
    reset = 1'b1;
    #1;
    check("areset.ld", 64'(rf_ld), 64'd0);
    check("areset.addr", 64'(rf_addr), 64'd0);
    check("areset.data", 64'(rf_data), 64'd0);
    check("areset.written", 64'(reg_written), 64'd0);
    check("areset.count", 64'(wr_count), 64'd0);
    check("areset.ready", 64'(req0_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, "areset_post");
    check("areset.no_ld", 64'(rf_ld), 64'd0);

    // Random traffic; pending requests stay stable until accepted.
    do_reset();
    c_v0 = 0; c_v1 = 0; c_a0 = 0; c_a1 = 0; c_d0 = 0; c_d1 = 0;
    s_r0 = 0; s_r1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(c_v0 && !s_r0)) begin
        c_v0 = 1'($urandom_range(0, 1)); c_a0 = 4'($urandom); c_d0 = $urandom;
      end
      if (!(c_v1 && !s_r1)) begin
        c_v1 = 1'($urandom_range(0, 1)); c_a1 = 4'($urandom); c_d1 = $urandom;
      end
      c_h = ($urandom_range(0, 7) == 0);
      step(c_v0, c_a0, c_d0, c_v1, c_a1, c_d1, c_h, "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
